// File: rtl/period_meter.sv
// Measures the period of a slow input in clk cycles, between consecutive synchronized rising edges.
// Latency: a result is valid sync_stages+1 clocks after sig_in is first sampled high.
// Backpressure: holds one result; a newer capture overwrites an unread one and pulses overrun.
module period_meter #(
    parameter int cnt_bits    = 16,
    parameter int sync_stages = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                sig_in,
    output logic [cnt_bits-1:0] period,
    output logic                period_valid,
    input  logic                period_ready,
    output logic                overrun,
    output logic                timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam logic [cnt_bits-1:0] CNT_MAX = '1;
    localparam logic [cnt_bits-1:0] CNT_ONE = {{(cnt_bits-1){1'b0}}, 1'b1};

    logic [sync_stages-1:0] r_sync;
    logic                   r_s_prev;
    logic                   r_rise;
    logic [1:0]             r_state;
    logic [cnt_bits-1:0]    r_count;
    logic [cnt_bits-1:0]    r_period;
    logic                   r_valid;
    logic                   r_overrun;
    logic                   r_timeout;

    logic                   w_s;
    logic                   w_capture;
    logic                   w_timeout_evt;

    assign w_s           = r_sync[sync_stages-1];
    assign w_capture     = en && (r_state == ST_MEAS) && r_rise;
    assign w_timeout_evt = en && (r_state == ST_MEAS) && !r_rise && (r_count == CNT_MAX);

    // Edge detection runs regardless of en so enabling never fabricates an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '0;
            r_s_prev <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[sync_stages-2:0], sig_in};
            r_s_prev <= w_s;
            r_rise   <= w_s & ~r_s_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else if (!en) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count <= '0;
                    r_state <= ST_ARM;
                end
                ST_ARM: begin
                    if (r_rise) begin
                        r_count <= CNT_ONE;
                        r_state <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (r_rise) begin
                        r_count <= CNT_ONE;
                    end else if (r_count == CNT_MAX) begin
                        r_count <= '0;
                        r_state <= ST_ARM;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                default: begin
                    r_count <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register survives en=0 so a pending result stays readable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_timeout <= w_timeout_evt;
            if (w_capture) begin
                r_period  <= r_count;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~period_ready;
            end else if (r_valid && period_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_valid;
    assign overrun      = r_overrun;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (cnt_bits=8 so the timeout case stays short).
module tb_period_meter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       sig_in;
    logic [7:0] period;
    logic       period_valid;
    logic       period_ready;
    logic       overrun;
    logic       timeout;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_ovr   = 0;
    int  n_to    = 0;
    bit  tog     = 1'b0;
    bit  found;

    period_meter #(
        .cnt_bits    (8),
        .sync_stages (2)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun) n_ovr++;
        if (timeout) n_to++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tog) sig_in = ~sig_in;
    endtask

    task automatic drive(input logic v, input int n);
        sig_in = v;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        sig_in       = 1'b0;
        period_ready = 1'b0;
        tick();
        tick();
        chk("rst_period", period, 0);
        chk("rst_valid", period_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b0;

        // 1: square wave 20/20, ready=1
        en = 1'b1;
        period_ready = 1'b1;
        drive(0, 3);
        for (int p = 0; p < 3; p++) begin
            drive(1, 4);
            if (p == 0) chk("t1_first_edge_no_result", period_valid, 0);
            else begin
                chk("t1_valid", period_valid, 1);
                chk("t1_period", period, 40);
            end
            tick();
            chk("t1_valid_cleared", period_valid, 0);
            drive(1, 15);
            drive(0, 20);
        end

        // 2: ready=0, spacing 40 then 50
        do_reset();
        period_ready = 1'b0;
        drive(0, 3);
        drive(1, 10);
        drive(0, 30);
        drive(1, 4);
        chk("t2_valid_a", period_valid, 1);
        chk("t2_period_a", period, 40);
        chk("t2_no_ovr_a", overrun, 0);
        drive(1, 6);
        drive(0, 40);
        drive(1, 4);
        chk("t2_period_b", period, 50);
        chk("t2_valid_b", period_valid, 1);
        chk("t2_overrun", overrun, 1);
        tick();
        chk("t2_overrun_1cyc", overrun, 0);
        period_ready = 1'b1;
        tick();
        period_ready = 1'b0;
        chk("t2_valid_consumed", period_valid, 0);
        chk("t2_period_hold", period, 50);
        drive(1, 4);
        drive(0, 10);

        // 3: timeout after 255 clks in MEAS, then a 30-cycle period
        do_reset();
        period_ready = 1'b1;
        drive(0, 3);
        drive(1, 10);
        drive(0, 248);
        chk("t3_no_timeout_early", timeout, 0);
        tick();
        chk("t3_timeout", timeout, 1);
        chk("t3_valid_after_to", period_valid, 0);
        tick();
        chk("t3_timeout_1cyc", timeout, 0);
        drive(1, 10);
        drive(0, 20);
        drive(1, 4);
        chk("t3_valid", period_valid, 1);
        chk("t3_period", period, 30);
        drive(1, 6);
        drive(0, 5);

        // 4: enable dropped mid-measurement
        do_reset();
        period_ready = 1'b0;
        drive(0, 3);
        drive(1, 10);
        drive(0, 26);
        drive(1, 4);
        chk("t4_pending_period", period, 36);
        drive(1, 6);
        drive(0, 4);
        en = 1'b0;
        drive(0, 5);
        drive(1, 5);
        drive(0, 5);
        chk("t4_pending_valid_en0", period_valid, 1);
        chk("t4_pending_period_en0", period, 36);
        period_ready = 1'b1;
        tick();
        period_ready = 1'b0;
        chk("t4_consumed_en0", period_valid, 0);
        en = 1'b1;
        drive(0, 3);
        drive(1, 4);
        chk("t4_rearm_no_result", period_valid, 0);
        drive(1, 6);
        drive(0, 30);
        drive(1, 4);
        chk("t4_valid", period_valid, 1);
        chk("t4_period", period, 40);

        // 5: reset with a pending result mid-MEAS
        drive(1, 6);
        drive(0, 10);
        reset = 1'b1;
        tick();
        chk("t5_period", period, 0);
        chk("t5_valid", period_valid, 0);
        reset = 1'b0;
        drive(0, 3);
        drive(1, 4);
        chk("t5_first_edge_arms", period_valid, 0);
        drive(0, 4);

        // 6: sig_in toggles every clk -> period 2
        do_reset();
        period_ready = 1'b1;
        sig_in = 1'b0;
        drive(0, 3);
        tog = 1'b1;
        repeat (12) tick();
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            if (period_valid) found = 1'b1;
            else tick();
        end
        chk("t6_valid_seen", found, 1);
        chk("t6_period", period, 2);
        period_ready = 1'b0;
        tick();
        chk("t6_hold_valid", period_valid, 1);
        period_ready = 1'b1;
        tick();
        chk("t6_same_cycle_valid", period_valid, 1);
        chk("t6_same_cycle_no_ovr", overrun, 0);
        chk("t6_same_cycle_period", period, 2);
        tick();
        chk("t6_cleared", period_valid, 0);
        tog = 1'b0;
        drive(0, 4);

        chk("overrun_pulses", n_ovr, 1);
        chk("timeout_pulses", n_to, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
